branch_ctrl: RTL and testbench

ID-stage branch sequencer for the 5-stage RV32I pipeline. It decodes the ID instruction's control-flow class and holds ID until the branch operands can be forwarded. It then consumes the comparator's taken flag (branch compare unit) and drives PC redirect, IF/ID flush and ID/EX bubble. It keeps saturating performance counters for branches, taken redirects and branch stall cycles.

---
 rtl/branch_ctrl_pkg.sv | 18 +
 rtl/branch_hazard_detect.sv | 39 +++
 rtl/branch_ctrl.sv | 146 ++++++++++++++
 tb/tb_branch_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the ID-stage branch sequencer: opcodes, FSM states
// and the width of the hazard "need" value.
package branch_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int NEED_W = 2;

  typedef logic [NEED_W-1:0] need_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational rs/rd compare: how many cycles ID must wait before its
// branch operands can be forwarded (0, 1 or 2).
module branch_hazard_detect
  import branch_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_memread,
  output need_t      need
);

  need_t need_rs1;
  need_t need_rs2;

  // x0 never creates a dependency; a load in EX is the longest wait.
  function automatic need_t src_need(input logic used, input logic [4:0] rs,
                                     input logic [4:0] e_rd, input logic e_wr,
                                     input logic e_ld, input logic [4:0] m_rd,
                                     input logic m_ld);
    if (!used || rs == 5'd0)       return need_t'(0);
    if (e_ld && e_rd == rs)        return need_t'(2);
    if (e_wr && e_rd == rs)        return need_t'(1);
    if (m_ld && m_rd == rs)        return need_t'(1);
    return need_t'(0);
  endfunction

  always_comb begin
    need_rs1 = src_need(rs1_used, rs1, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread);
    need_rs2 = src_need(rs2_used, rs2, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread);
    need     = (need_rs1 > need_rs2) ? need_rs1 : need_rs2;
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: holds ID on operand hazards, then resolves the
// control-flow instruction into redirect/flush, with saturating perf counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic [XLEN-1:0]  jalr_target,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_memread,
  input  logic             ext_stall,
  input  logic             kill,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stall
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q, state_d;
  need_t            hold_q, hold_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic            is_br, is_jal, is_jalr, is_ctrl, take;
  logic            stall_c, bubble_c, flush_c, redirect_c;
  logic [XLEN-1:0] pc_c;
  need_t           need;
  logic            unused_inst_bits;

  assign is_br   = (id_inst[6:0] == OP_BRANCH);
  assign is_jal  = (id_inst[6:0] == OP_JAL);
  assign is_jalr = (id_inst[6:0] == OP_JALR);
  assign is_ctrl = id_valid & (is_br | is_jal | is_jalr);
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  branch_hazard_detect u_hazard (
    .rs1         (id_inst[19:15]),
    .rs2         (id_inst[24:20]),
    .rs1_used    (is_br | is_jalr),
    .rs2_used    (is_br),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .mem_rd      (mem_rd),
    .mem_memread (mem_memread),
    .need        (need)
  );

  // kill beats ext_stall, which beats normal sequencing.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cnt_branch_d = cnt_branch_q;
    cnt_taken_d  = cnt_taken_q;
    cnt_stall_d  = cnt_stall_q;
    stall_c      = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    redirect_c   = 1'b0;
    pc_c         = '0;
    take         = 1'b0;
    if (kill) begin
      state_d = RUN;
      hold_d  = '0;
    end else if (ext_stall) begin
      stall_c = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (is_ctrl) begin
            if (need != '0) begin
              stall_c     = 1'b1;
              bubble_c    = 1'b1;
              state_d     = HOLD;
              hold_d      = need - need_t'(1);
              cnt_stall_d = sat_inc(cnt_stall_q);
            end else begin
              take         = is_jal | is_jalr | (is_br & br_taken);
              redirect_c   = take;
              flush_c      = take;
              pc_c         = is_jalr ? jalr_target : br_target;
              cnt_branch_d = sat_inc(cnt_branch_q);
              if (take) cnt_taken_d = sat_inc(cnt_taken_q);
            end
          end
        end
        HOLD: begin
          stall_c     = 1'b1;
          bubble_c    = 1'b1;
          cnt_stall_d = sat_inc(cnt_stall_q);
          if (hold_q == '0) state_d = RUN;
          else              hold_d  = hold_q - need_t'(1);
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= RUN;
      hold_q       <= '0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign stall_if_id  = rstn & stall_c;
  assign bubble_id_ex = rstn & bubble_c;
  assign flush_if_id  = rstn & flush_c;
  assign redirect     = rstn & redirect_c;
  assign redirect_pc  = rstn ? pc_c : '0;
  assign cnt_branch   = cnt_branch_q;
  assign cnt_taken    = cnt_taken_q;
  assign cnt_stall    = cnt_stall_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model that counts remaining hold cycles directly.
module tb_branch_ctrl;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 8;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic             br_taken;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  jalr_target;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_memread;
  logic             ext_stall;
  logic             kill;
  logic             stall_if_id;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_stall;

  int vectors = 0;
  int miscompares = 0;

  // Model state: number of HOLD cycles still owed (0 means running) and counters.
  int     m_hold, n_hold;
  longint m_branch, m_taken, m_stall, n_branch, n_taken, n_stall;
  logic [3:0]      e_ctl;  // {stall, bubble, flush, redirect}
  logic [XLEN-1:0] e_pc;

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_inst(id_inst),
    .br_taken(br_taken), .br_target(br_target), .jalr_target(jalr_target),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_memread(mem_memread), .ext_stall(ext_stall),
    .kill(kill), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .redirect(redirect), .redirect_pc(redirect_pc),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_br(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, f3, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] mk_jal();
    return {20'h00010, 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] mk_jalr(input logic [4:0] r1);
    return {12'h004, r1, 3'd0, 5'd1, 7'b1100111};
  endfunction

  function automatic longint sat(input longint v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic int src_need(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (ex_memread && ex_rd == r) return 2;
    if ((ex_regwrite && ex_rd == r) || (mem_memread && mem_rd == r)) return 1;
    return 0;
  endfunction

  task automatic model_eval();
    logic [6:0] op;
    bit br, jal, jalr, ctl, take;
    int need;
    e_ctl = 4'b0000; e_pc = '0;
    n_hold = m_hold; n_branch = m_branch; n_taken = m_taken; n_stall = m_stall;
    if (!rstn) begin
      m_hold = 0; m_branch = 0; m_taken = 0; m_stall = 0;
      n_hold = 0; n_branch = 0; n_taken = 0; n_stall = 0;
      return;
    end
    op = id_inst[6:0];
    br = (op == 7'h63); jal = (op == 7'h6F); jalr = (op == 7'h67);
    ctl = id_valid && (br || jal || jalr);
    if (kill) begin
      n_hold = 0;
    end else if (ext_stall) begin
      e_ctl = 4'b1000;
    end else if (m_hold > 0) begin
      e_ctl = 4'b1100; n_stall = sat(m_stall); n_hold = m_hold - 1;
    end else if (ctl) begin
      need = 0;
      if (br || jalr) need = src_need(id_inst[19:15]);
      if (br && src_need(id_inst[24:20]) > need) need = src_need(id_inst[24:20]);
      if (need > 0) begin
        e_ctl = 4'b1100; n_stall = sat(m_stall); n_hold = need;
      end else begin
        take = jal || jalr || (br && br_taken);
        e_ctl = take ? 4'b0011 : 4'b0000;
        e_pc = jalr ? jalr_target : br_target;
        n_branch = sat(m_branch);
        if (take) n_taken = sat(m_taken);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) begin
      m_hold = n_hold; m_branch = n_branch; m_taken = n_taken; m_stall = n_stall;
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_inst = 32'h0000_0013; br_taken = 1'b0;
    br_target = '0; jalr_target = '0; ex_rd = '0; ex_regwrite = 1'b0;
    ex_memread = 1'b0; mem_rd = '0; mem_memread = 1'b0; ext_stall = 1'b0; kill = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rstn = 1'b0;
    id_valid = 1'b1; id_inst = mk_jal(); br_target = 32'h40;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ctl: got %b want 0000", {stall_if_id, bubble_id_ex, flush_if_id, redirect});
    end
    vectors++;
    if ({cnt_branch, cnt_taken, cnt_stall} !== '0) begin
      miscompares++; $display("FAIL reset_cnt: got %h/%h/%h want 0/0/0", cnt_branch, cnt_taken, cnt_stall);
    end
    @(negedge clk);
    rstn = 1'b1;
    set_idle();
  endtask

  task automatic test_beq_taken();
    set_idle();
    id_valid = 1'b1; id_inst = mk_br(3'b000, 5'd5, 5'd6); br_taken = 1'b1;
    br_target = 32'h100; jalr_target = 32'h999;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0011 || redirect_pc !== 32'h100) begin
      miscompares++; $display("FAIL beq_redirect: got ctl %b pc %h want 0011 pc 00000100",
                              {stall_if_id, bubble_id_ex, flush_if_id, redirect}, redirect_pc);
    end
    tick();
    set_idle();
    #1;
    vectors++;
    if (cnt_branch !== 8'd1 || cnt_taken !== 8'd1) begin
      miscompares++; $display("FAIL beq_counters: got br %0d tk %0d want 1 1", cnt_branch, cnt_taken);
    end
  endtask

  task automatic test_bne_loaduse();
    logic [CNT_W-1:0] st0, br0;
    set_idle();
    st0 = cnt_stall; br0 = cnt_branch;
    id_valid = 1'b1; id_inst = mk_br(3'b001, 5'd5, 5'd9); br_target = 32'h200;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
    for (int c = 0; c < 3; c++) begin
      model_eval();
      #1;
      vectors++;
      if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b1100 || e_ctl !== 4'b1100) begin
        miscompares++; $display("FAIL bne_hold_c%0d: got %b model %b want 1100", c,
                                {stall_if_id, bubble_id_ex, flush_if_id, redirect}, e_ctl);
      end
      tick();
    end
    ex_memread = 1'b0; ex_regwrite = 1'b0; br_taken = 1'b0;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0000) begin
      miscompares++; $display("FAIL bne_resolve: got %b want 0000", {stall_if_id, bubble_id_ex, flush_if_id, redirect});
    end
    tick();
    set_idle();
    #1;
    vectors++;
    if (cnt_stall !== CNT_W'(st0 + 3) || cnt_branch !== CNT_W'(br0 + 1)) begin
      miscompares++; $display("FAIL bne_counters: got stall %0d br %0d want %0d %0d",
                              cnt_stall, cnt_branch, st0 + 3, br0 + 1);
    end
  endtask

  task automatic test_jalr_x0();
    set_idle();
    id_valid = 1'b1; id_inst = mk_jalr(5'd0); ex_regwrite = 1'b1; ex_rd = 5'd0;
    jalr_target = 32'h2000; br_target = 32'h3000;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0011 || redirect_pc !== 32'h2000) begin
      miscompares++; $display("FAIL jalr_x0: got ctl %b pc %h want 0011 pc 00002000",
                              {stall_if_id, bubble_id_ex, flush_if_id, redirect}, redirect_pc);
    end
    tick();
  endtask

  task automatic test_ext_stall_hold();
    logic [CNT_W-1:0] st0;
    set_idle();
    id_valid = 1'b1; id_inst = mk_br(3'b001, 5'd7, 5'd0);
    ex_memread = 1'b1; ex_rd = 5'd7;
    model_eval(); tick();
    set_idle();
    id_valid = 1'b1; id_inst = mk_br(3'b001, 5'd7, 5'd0);
    st0 = cnt_stall;
    ext_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      model_eval();
      #1;
      vectors++;
      if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b1000 || cnt_stall !== st0) begin
        miscompares++; $display("FAIL xstall_c%0d: got ctl %b stall_cnt %0d want 1000 %0d", c,
                                {stall_if_id, bubble_id_ex, flush_if_id, redirect}, cnt_stall, st0);
      end
      tick();
    end
    ext_stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      model_eval();
      #1;
      vectors++;
      if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b1100) begin
        miscompares++; $display("FAIL xstall_resume_c%0d: got %b want 1100", c,
                                {stall_if_id, bubble_id_ex, flush_if_id, redirect});
      end
      tick();
    end
    br_taken = 1'b1; br_target = 32'h480;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0011 || cnt_stall !== CNT_W'(st0 + 2)) begin
      miscompares++; $display("FAIL xstall_exit: got ctl %b stall_cnt %0d want 0011 %0d",
                              {stall_if_id, bubble_id_ex, flush_if_id, redirect}, cnt_stall, st0 + 2);
    end
    tick();
  endtask

  task automatic test_kill();
    logic [CNT_W-1:0] br0, st0;
    set_idle();
    id_valid = 1'b1; id_inst = mk_br(3'b000, 5'd3, 5'd4); ex_memread = 1'b1; ex_rd = 5'd4;
    model_eval(); tick();
    br0 = cnt_branch; st0 = cnt_stall;
    kill = 1'b1; ext_stall = 1'b1;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0000) begin
      miscompares++; $display("FAIL kill_ctl: got %b want 0000", {stall_if_id, bubble_id_ex, flush_if_id, redirect});
    end
    tick();
    kill = 1'b0; ext_stall = 1'b0; ex_memread = 1'b0; br_taken = 1'b1; br_target = 32'h5a0;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0011 || cnt_branch !== br0 || cnt_stall !== st0) begin
      miscompares++; $display("FAIL kill_run: got ctl %b br %0d st %0d want 0011 %0d %0d",
                              {stall_if_id, bubble_id_ex, flush_if_id, redirect}, cnt_branch, cnt_stall, br0, st0);
    end
    tick();
  endtask

  task automatic test_random();
    int kind;
    for (int c = 0; c < 400; c++) begin
      kind = $urandom_range(0, 3);
      id_valid = ($urandom_range(0, 9) < 8);
      case (kind)
        0: id_inst = mk_br(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        1: id_inst = mk_jal();
        2: id_inst = mk_jalr(5'($urandom_range(0, 7)));
        default: id_inst = {$urandom_range(0, 32'h1FF_FFFF), 7'b0110011};
      endcase
      br_taken = $urandom_range(0, 1); br_target = $urandom; jalr_target = $urandom & ~32'd1;
      ex_rd = 5'($urandom_range(0, 7)); ex_regwrite = $urandom_range(0, 1);
      ex_memread = ($urandom_range(0, 3) == 0); mem_rd = 5'($urandom_range(0, 7));
      mem_memread = ($urandom_range(0, 3) == 0);
      ext_stall = ($urandom_range(0, 9) == 0); kill = ($urandom_range(0, 19) == 0);
      model_eval();
      #1;
      vectors++;
      if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== e_ctl ||
          (e_ctl[0] && redirect_pc !== e_pc)) begin
        miscompares++; $display("FAIL rand_out_c%0d: got ctl %b pc %h want %b pc %h", c,
                                {stall_if_id, bubble_id_ex, flush_if_id, redirect}, redirect_pc, e_ctl, e_pc);
      end
      vectors++;
      if (cnt_branch !== CNT_W'(m_branch) || cnt_taken !== CNT_W'(m_taken) || cnt_stall !== CNT_W'(m_stall)) begin
        miscompares++; $display("FAIL rand_cnt_c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                                cnt_branch, cnt_taken, cnt_stall, m_branch, m_taken, m_stall);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_saturate_and_reset();
    int extra = 0;
    set_idle();
    for (int i = 0; i < 400 && extra < 2; i++) begin
      if (m_taken == CNT_MAX) extra++;
      id_valid = 1'b1; id_inst = mk_jal(); br_target = 32'($urandom);
      model_eval();
      #1;
      vectors++;
      if (redirect !== 1'b1 || cnt_taken !== CNT_W'(m_taken)) begin
        miscompares++; $display("FAIL sat_jal_%0d: got redir %b tk %0d want 1 %0d", i, redirect, cnt_taken, m_taken);
      end
      tick();
    end
    set_idle();
    #1;
    vectors++;
    if (cnt_taken !== 8'hFF || extra != 2) begin
      miscompares++; $display("FAIL sat_final: got tk %h (extra %0d) want ff (extra 2)", cnt_taken, extra);
    end
    id_valid = 1'b1; id_inst = mk_br(3'b001, 5'd5, 5'd6); ex_memread = 1'b1; ex_rd = 5'd5;
    model_eval(); tick();
    #2;
    rstn = 1'b0;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0000 || redirect_pc !== '0 ||
        {cnt_branch, cnt_taken, cnt_stall} !== '0) begin
      miscompares++; $display("FAIL rst_mid_hold: got ctl %b pc %h cnt %h/%h/%h want all zero",
                              {stall_if_id, bubble_id_ex, flush_if_id, redirect}, redirect_pc,
                              cnt_branch, cnt_taken, cnt_stall);
    end
    @(negedge clk);
    rstn = 1'b1;
    ex_memread = 1'b0; br_taken = 1'b1; br_target = 32'h7c0;
    model_eval();
    #1;
    vectors++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, redirect} !== 4'b0011 || redirect_pc !== 32'h7c0) begin
      miscompares++; $display("FAIL rst_then_run: got ctl %b pc %h want 0011 pc 000007c0",
                              {stall_if_id, bubble_id_ex, flush_if_id, redirect}, redirect_pc);
    end
    tick();
    #1;
    vectors++;
    if (cnt_branch !== 8'd1 || cnt_taken !== 8'd1 || cnt_stall !== 8'd0) begin
      miscompares++; $display("FAIL rst_then_cnt: got %0d/%0d/%0d want 1/1/0", cnt_branch, cnt_taken, cnt_stall);
    end
  endtask

  initial begin
    m_hold = 0; m_branch = 0; m_taken = 0; m_stall = 0;
    rstn = 1'b0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_beq_taken();
    test_bne_loaduse();
    test_jalr_x0();
    test_ext_stall_hold();
    test_kill();
    test_random();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
